// File: rtl/nand_tester_pkg.sv
// Shared definitions for the NAND truth-table exerciser: FSM state encoding,
// vector-sequence constants, the fixed uio output-enable pattern and the
// expected-response helper.
package nand_tester_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int         NUM_VEC    = 4;
    localparam logic [1:0] LAST_VEC   = 2'd3;
    localparam logic [7:0] UIO_OE_VAL = 8'b0000_0011;

    // Expected NAND output for a {B,A} vector, optionally inverted to inject a fault
    function automatic logic nand_expect(input logic [1:0] ab, input logic invert);
        return (~(ab[0] & ab[1])) ^ invert;
    endfunction

endpackage

// File: rtl/tt_sync2.sv
// Two-flop synchroniser with asynchronous active-low reset, used for the
// asynchronous control pins and the external NAND response.
module tt_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two back-to-back flops give metastability a full cycle to resolve
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tt_um_akanksha_hu8785_nand_tester.sv
// On-chip NAND truth-table exerciser (TinyTapeout tile pinout).
// Drives {B,A} on uio_out[1:0] through 00,01,10,11, samples the NAND response
// and reports busy/done/pass/fail plus a saturating error count on uo_out.
// Optional build macro NAND_TESTER_LOOPBACK_EN: the response comes from an
// internal registered NAND of uio_out[1:0] instead of uio_in[2].
module tt_um_akanksha_hu8785_nand_tester
    import nand_tester_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int ERR_W         = 4
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    localparam int               VEC_W       = $clog2(NUM_VEC);
    localparam int               CNT_W       = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;

    state_t             state;
    state_t             state_next;
    logic               run_start;
    logic               clear_err;
    logic [1:0]         ctrl_sync;
    logic               start_prev;
    logic               start_pulse;
    logic               cont_mode;
    logic               resp;
    logic               mismatch;
    logic [VEC_W-1:0]   vec;
    logic [1:0]         ab;
    logic [CNT_W-1:0]   settle_cnt;
    logic [ERR_W-1:0]   err_cnt;
    logic               fail;
    logic               run_err;
    logic               busy;
    logic               done;
    logic               pass;
    logic               unused_inputs;

    tt_sync2 #(.WIDTH(2)) u_ctrl_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ui_in[1:0]),
        .q     (ctrl_sync)
    );

`ifdef NAND_TESTER_LOOPBACK_EN
    logic loop_resp;

    // Internal NAND of the driven vector, registered once, stands in for the external part
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loop_resp <= 1'b1;
        end else begin
            loop_resp <= ~(ab[0] & ab[1]);
        end
    end

    assign resp          = loop_resp;
    assign unused_inputs = &{1'b0, ena, ui_in[7:3], uio_in[7:0]};
`else
    tt_sync2 #(.WIDTH(1)) u_resp_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (uio_in[2]),
        .q     (resp)
    );

    assign unused_inputs = &{1'b0, ena, ui_in[7:3], uio_in[7:3], uio_in[1:0]};
`endif

    // Delayed copy of the synced start level for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_prev <= 1'b0;
        end else begin
            start_prev <= ctrl_sync[0];
        end
    end

    assign start_pulse = ctrl_sync[0] & ~start_prev;
    assign cont_mode   = ctrl_sync[1];
    assign mismatch    = resp != nand_expect(ab, ui_in[2]);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; continuous mode restarts without clearing the error count
    always_comb begin
        state_next = state;
        run_start  = 1'b0;
        clear_err  = 1'b0;
        case (state)
            IDLE: begin
                if (start_pulse) begin
                    state_next = DRIVE;
                    run_start  = 1'b1;
                    clear_err  = 1'b1;
                end
            end
            DRIVE: begin
                state_next = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                if (vec == LAST_VEC) begin
                    state_next = DONE;
                end else begin
                    state_next = DRIVE;
                end
            end
            DONE: begin
                if (cont_mode) begin
                    state_next = DRIVE;
                    run_start  = 1'b1;
                end else if (start_pulse) begin
                    state_next = DRIVE;
                    run_start  = 1'b1;
                    clear_err  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Vector, stimulus, settle counter and error bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec        <= '0;
            ab         <= 2'b00;
            settle_cnt <= '0;
            err_cnt    <= '0;
            fail       <= 1'b0;
            run_err    <= 1'b0;
        end else begin
            if (run_start) begin
                vec     <= '0;
                run_err <= 1'b0;
                if (clear_err) begin
                    err_cnt <= '0;
                end
            end
            case (state)
                DRIVE: begin
                    ab         <= vec;
                    settle_cnt <= '0;
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt + 1'b1;
                end
                SAMPLE: begin
                    if (mismatch) begin
                        fail    <= 1'b1;
                        run_err <= 1'b1;
                        if (err_cnt != ERR_MAX) begin
                            err_cnt <= err_cnt + 1'b1;
                        end
                    end
                    if (vec != LAST_VEC) begin
                        vec <= vec + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state == DRIVE) || (state == SETTLE) || (state == SAMPLE);
    assign done = (state == DONE);
    assign pass = done && !run_err;

    assign uo_out  = {4'(err_cnt), fail, pass, done, busy};
    assign uio_out = {6'b00_0000, ab};
    assign uio_oe  = UIO_OE_VAL;

endmodule

// File: tb/tb_tt_um_akanksha_hu8785_nand_tester.sv
// Self-checking bench for the NAND truth-table exerciser. A run-level model
// (start latency, run offset, per-vector mismatch rule) predicts uo_out and
// uio_out every cycle; directed tests add hand-computed literal checks.
module tb_tt_um_akanksha_hu8785_nand_tester;

    localparam int PER_VEC = 4 + 2;
    localparam int RUN_LEN = 4 * PER_VEC;

    typedef enum int {NAND_GOOD, STUCK1, STUCK0} resp_mode_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena   = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       rand_bit = 1'b0;
    resp_mode_t resp_mode = NAND_GOOD;

    int checks = 0;
    int errors = 0;

    logic [3:0] start_hist = 4'b0;
    logic [3:0] cont_hist  = 4'b0;
    logic       m_run      = 1'b0;
    int         m_k        = 0;
    logic       m_done     = 1'b0;
    logic       m_run_err  = 1'b0;
    logic       m_fail     = 1'b0;
    int         m_err      = 0;
    logic [1:0] m_ab       = 2'b00;

    tt_um_akanksha_hu8785_nand_tester dut (
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    always #5 clk = ~clk;

    // External NAND (or faulty part) answering the driven vector
    always_comb begin
        uio_in = 8'h00;
`ifdef NAND_TESTER_LOOPBACK_EN
        uio_in[2] = rand_bit;
`else
        case (resp_mode)
            STUCK1:  uio_in[2] = 1'b1;
            STUCK0:  uio_in[2] = 1'b0;
            default: uio_in[2] = ~(uio_out[0] & uio_out[1]);
        endcase
`endif
    end

    // Noise on the response pin, only meaningful when it must be ignored
    always @(negedge clk) begin
        rand_bit <= 1'($urandom_range(0, 1));
    end

    function automatic logic vec_mismatch(input logic [1:0] v, input logic inv);
        logic nand_v;
        logic y;
        nand_v = ~(v[0] & v[1]);
`ifdef NAND_TESTER_LOOPBACK_EN
        y = nand_v;
`else
        case (resp_mode)
            STUCK1:  y = 1'b1;
            STUCK0:  y = 1'b0;
            default: y = nand_v;
        endcase
`endif
        return y != (nand_v ^ inv);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Run-level model: start takes effect two edges after the synced edge, a run is 24 cycles
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_hist <= 4'b0;
            cont_hist  <= 4'b0;
            m_run      <= 1'b0;
            m_k        <= 0;
            m_done     <= 1'b0;
            m_run_err  <= 1'b0;
            m_fail     <= 1'b0;
            m_err      <= 0;
            m_ab       <= 2'b00;
        end else begin
            if (m_run) begin
                if (m_k % PER_VEC == 0) begin
                    m_ab <= 2'(m_k / PER_VEC);
                end
                if ((m_k % PER_VEC == PER_VEC - 1) && vec_mismatch(2'(m_k / PER_VEC), ui_in[2])) begin
                    m_fail    <= 1'b1;
                    m_run_err <= 1'b1;
                    if (m_err < 15) begin
                        m_err <= m_err + 1;
                    end
                end
                if (m_k == RUN_LEN - 1) begin
                    m_run  <= 1'b0;
                    m_done <= 1'b1;
                end else begin
                    m_k <= m_k + 1;
                end
            end else if (m_done && cont_hist[1]) begin
                m_run     <= 1'b1;
                m_k       <= 0;
                m_done    <= 1'b0;
                m_run_err <= 1'b0;
            end else if (start_hist[1] && !start_hist[2]) begin
                m_run     <= 1'b1;
                m_k       <= 0;
                m_done    <= 1'b0;
                m_run_err <= 1'b0;
                m_err     <= 0;
            end
            start_hist <= {start_hist[2:0], ui_in[0]};
            cont_hist  <= {cont_hist[2:0], ui_in[1]};
        end
    end

    // Every-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        checkOutput("uo_out vs model", int'(uo_out),
                    int'({m_err[3:0], m_fail, m_done && !m_run_err, m_done, m_run}));
        checkOutput("uio_out vs model", int'(uio_out), int'({6'b0, m_ab}));
        checkOutput("uio_oe", int'(uio_oe), 8'h03);
    end

    task automatic applyStimulus(input logic inv, input logic cont);
        @(negedge clk);
        ui_in[2] = inv;
        ui_in[1] = cont;
        ui_in[0] = 1'b1;
        repeat (2) @(negedge clk);
        ui_in[0] = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic waitDone(input string name, output int busy_cycles,
                            output logic [7:0] seq_code, output int seq_len);
        logic       started;
        logic       seen;
        logic [1:0] last;
        started     = 1'b0;
        seen        = 1'b0;
        last        = 2'b00;
        busy_cycles = 0;
        seq_code    = 8'h00;
        seq_len     = 0;
        for (int i = 0; i < RUN_LEN + 20 && !seen; i++) begin
            @(negedge clk);
            if (uo_out[0]) begin
                started = 1'b1;
            end
            if (started) begin
                if (uo_out[1]) begin
                    seen = 1'b1;
                end else if (uo_out[0]) begin
                    busy_cycles++;
                    if (seq_len == 0 || uio_out[1:0] != last) begin
                        if (seq_len < 4) begin
                            seq_code[2*seq_len +: 2] = uio_out[1:0];
                        end
                        seq_len++;
                        last = uio_out[1:0];
                    end
                end
            end
        end
        if (!seen) begin
            checkOutput({name, " done timeout"}, 0, 1);
        end
    endtask

    initial begin
        int         busy_cycles;
        logic [7:0] seq_code;
        int         seq_len;
        logic       seen;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checkOutput("reset uo_out", int'(uo_out), 8'h00);
        checkOutput("reset uio_out", int'(uio_out), 8'h00);
        checkOutput("reset uio_oe", int'(uio_oe), 8'h03);
        repeat (2) @(negedge clk);

`ifdef NAND_TESTER_LOOPBACK_EN
        for (int r = 0; r < 4; r++) begin
            applyStimulus(1'b0, 1'b0);
            waitDone("loopback run", busy_cycles, seq_code, seq_len);
            checkOutput("loopback result", int'(uo_out), 8'h06);
            checkOutput("loopback busy length", busy_cycles, 24);
        end
`else
        // Good NAND: full pass, vectors stepped in order
        resp_mode = NAND_GOOD;
        applyStimulus(1'b0, 1'b0);
        waitDone("good run", busy_cycles, seq_code, seq_len);
        checkOutput("good busy length", busy_cycles, 24);
        checkOutput("good vector count", seq_len, 4);
        checkOutput("good vector order", int'(seq_code), 8'hE4);
        checkOutput("good result", int'(uo_out), 8'h06);

        // Reset asserted while vector 2 is settling
        applyStimulus(1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = uo_out[0];
        end
        checkOutput("midrun busy seen", int'(seen), 1);
        repeat (13) @(negedge clk);
        checkOutput("midrun vector", int'(uio_out), 8'h02);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("midrun reset uo_out", int'(uo_out), 8'h00);
        checkOutput("midrun reset uio_out", int'(uio_out), 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("idle after reset", int'(uo_out), 8'h00);

        // Response stuck at 1: only vector 11 mismatches
        resp_mode = STUCK1;
        applyStimulus(1'b0, 1'b0);
        waitDone("stuck1 run", busy_cycles, seq_code, seq_len);
        checkOutput("stuck1 result", int'(uo_out), 8'h1A);

        // Inverted expectation with a good NAND: all four mismatch
        resp_mode = NAND_GOOD;
        applyStimulus(1'b1, 1'b0);
        waitDone("invert run", busy_cycles, seq_code, seq_len);
        checkOutput("invert result", int'(uo_out), 8'h4A);
        applyStimulus(1'b0, 1'b0);
        waitDone("recover run", busy_cycles, seq_code, seq_len);
        checkOutput("recover result", int'(uo_out), 8'h0E);

        // Continuous mode, stuck at 0: three mismatches per run, saturating at 15
        doReset();
        resp_mode = STUCK0;
        applyStimulus(1'b0, 1'b1);
        for (int r = 0; r < 6; r++) begin
            waitDone("continuous run", busy_cycles, seq_code, seq_len);
            checkOutput("continuous err_cnt", int'(uo_out[7:4]), (3 * (r + 1) > 15) ? 15 : 3 * (r + 1));
            if (r == 1) begin
                repeat (5) @(negedge clk);
                ui_in[0] = 1'b1;
                repeat (2) @(negedge clk);
                ui_in[0] = 1'b0;
            end
        end
        repeat (3) @(negedge clk);
        ui_in[1] = 1'b0;
        waitDone("final continuous run", busy_cycles, seq_code, seq_len);
        repeat (30) @(negedge clk);
        checkOutput("continuous hold", int'(uo_out), 8'hFA);
`endif

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
